regmem_port_arbiter: RTL and testbench

- Shares one two-port masked register memory (independent read port and write port, single clock domain) among PORTS requesters.
- Two independent round-robin arbiters: one grants the read port, one grants the write port, each at most once per cycle.
- Read and write can therefore both issue in the same cycle.
- Read data returns to the granted requester one cycle after acceptance, with a valid strobe and a requester ID.

---
 rtl/regmem_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/regmem_port_arbiter.sv | 105 ++++++++++
 tb/tb_regmem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regmem_arb_pkg.sv
// Shared sizing helpers and index types for the register-memory port arbiter.
package regmem_arb_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PORTS_DEF  = 4;
    localparam int HEIGHT_DEF = 16;
    localparam int AW_DEF     = clog2_min1(HEIGHT_DEF);
    localparam int ID_W_DEF   = clog2_min1(PORTS_DEF);

    typedef logic [ID_W_DEF-1:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal rotating pointer.
module rr_arbiter
    import regmem_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2_min1(N)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gntIdx_o
);

    logic [IW-1:0] ptr_q;
    logic          any_gnt;
    int            cand;

    // Grants are suppressed while reset is held so nothing reaches the memory.
    always_comb begin
        gnt_o    = '0;
        gntIdx_o = '0;
        any_gnt  = 1'b0;
        cand     = 0;
        if (reset_n_i) begin
            for (int k = 0; k < N; k++) begin
                cand = (int'(ptr_q) + k) % N;
                if (!any_gnt && req_i[IW'(cand)]) begin
                    any_gnt            = 1'b1;
                    gnt_o[IW'(cand)]   = 1'b1;
                    gntIdx_o           = IW'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else if (any_gnt) begin
            ptr_q <= (gntIdx_o == IW'(N - 1)) ? '0 : gntIdx_o + 1'b1;
        end
    end

endmodule

// File: rtl/regmem_port_arbiter.sv
// Shares a two-port masked register memory among PORTS requesters with
// independent round-robin arbitration of the read and write ports.
module regmem_port_arbiter
    import regmem_arb_pkg::*;
#(
    parameter  int PORTS  = 4,
    parameter  int WIDTH  = 16,
    parameter  int HEIGHT = 16,
    parameter  int MASK   = 4,
    localparam int AW     = clog2_min1(HEIGHT),
    localparam int IDW    = clog2_min1(PORTS)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [PORTS-1:0]        reqValid_i,
    input  logic [PORTS-1:0]        reqWrite_i,
    input  logic [PORTS*AW-1:0]     reqAddr_i,
    input  logic [PORTS*MASK-1:0]   reqMask_i,
    input  logic [PORTS*WIDTH-1:0]  reqData_i,
    output logic [PORTS-1:0]        reqReady_o,
    output logic [PORTS-1:0]        rspValid_o,
    output logic [IDW-1:0]          rspId_o,
    output logic [WIDTH-1:0]        rspData_o,
    output logic                    memReadEnable_o,
    output logic [AW-1:0]           memReadAddr_o,
    input  logic [WIDTH-1:0]        memReadData_i,
    output logic                    memWriteEnable_o,
    output logic [MASK-1:0]         memWriteMask_o,
    output logic [AW-1:0]           memWriteAddr_o,
    output logic [WIDTH-1:0]        memWriteData_o
);

    logic [AW-1:0]    addr_a [PORTS];
    logic [MASK-1:0]  mask_a [PORTS];
    logic [WIDTH-1:0] data_a [PORTS];

    logic [PORTS-1:0] rd_req, wr_req;
    logic [PORTS-1:0] rd_gnt, wr_gnt;
    logic [IDW-1:0]   rd_idx, wr_idx;

    logic             rsp_vld_q;
    logic [IDW-1:0]   rsp_id_q;

    for (genvar g = 0; g < PORTS; g++) begin : g_unpack
        assign addr_a[g]     = reqAddr_i[g*AW +: AW];
        assign mask_a[g]     = reqMask_i[g*MASK +: MASK];
        assign data_a[g]     = reqData_i[g*WIDTH +: WIDTH];
        assign rspValid_o[g] = rsp_vld_q && (rsp_id_q == IDW'(g));
    end

    assign rd_req = reqValid_i & ~reqWrite_i;
    assign wr_req = reqValid_i &  reqWrite_i;

    rr_arbiter #(.N(PORTS)) u_rd_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req_i     (rd_req),
        .gnt_o     (rd_gnt),
        .gntIdx_o  (rd_idx)
    );

    rr_arbiter #(.N(PORTS)) u_wr_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req_i     (wr_req),
        .gnt_o     (wr_gnt),
        .gntIdx_o  (wr_idx)
    );

    assign reqReady_o = rd_gnt | wr_gnt;

    // Memory outputs stay at zero when their port is idle.
    always_comb begin
        memReadEnable_o  = |rd_gnt;
        memReadAddr_o    = '0;
        memWriteEnable_o = |wr_gnt;
        memWriteAddr_o   = '0;
        memWriteMask_o   = '0;
        memWriteData_o   = '0;
        if (|rd_gnt) begin
            memReadAddr_o = addr_a[rd_idx];
        end
        if (|wr_gnt) begin
            memWriteAddr_o = addr_a[wr_idx];
            memWriteMask_o = mask_a[wr_idx];
            memWriteData_o = data_a[wr_idx];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            rsp_vld_q <= |rd_gnt;
            if (|rd_gnt) begin
                rsp_id_q <= rd_idx;
            end
        end
    end

    assign rspId_o   = rsp_id_q;
    assign rspData_o = memReadData_i;

endmodule

// File: tb/tb_regmem_port_arbiter.sv
// Bench for regmem_port_arbiter: behavioural memory, directed scenarios and
// randomized traffic checked against an arbitration/memory reference model.
module tb_regmem_port_arbiter;

    localparam int PORTS  = 4;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 16;
    localparam int MASK   = 4;
    localparam int AW     = 4;
    localparam int IDW    = 2;
    localparam int CW     = WIDTH / MASK;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;

    logic [PORTS-1:0] valid = '0;
    logic [PORTS-1:0] write = '0;
    logic [AW-1:0]    addr [PORTS];
    logic [MASK-1:0]  mask [PORTS];
    logic [WIDTH-1:0] data [PORTS];

    logic [PORTS*AW-1:0]    req_addr;
    logic [PORTS*MASK-1:0]  req_mask;
    logic [PORTS*WIDTH-1:0] req_data;

    logic [PORTS-1:0] reqReady_o, rspValid_o;
    logic [IDW-1:0]   rspId_o;
    logic [WIDTH-1:0] rspData_o;
    logic             mem_re, mem_we;
    logic [AW-1:0]    mem_raddr, mem_waddr;
    logic [MASK-1:0]  mem_wmask;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    logic [WIDTH-1:0] mem     [HEIGHT];
    logic [WIDTH-1:0] ref_mem [HEIGHT];

    int n_chk = 0;
    int n_err = 0;
    int rd_ptr = 0;
    int wr_ptr = 0;
    int last_gr = -1;
    int last_gw = -1;
    logic [PORTS-1:0] obs_ready;

    always #5 clk_i = ~clk_i;

    always_comb begin
        req_addr = '0;
        req_mask = '0;
        req_data = '0;
        for (int p = 0; p < PORTS; p++) begin
            req_addr[p*AW +: AW]       = addr[p];
            req_mask[p*MASK +: MASK]   = mask[p];
            req_data[p*WIDTH +: WIDTH] = data[p];
        end
    end

    regmem_port_arbiter #(
        .PORTS(PORTS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (rst_n),
        .reqValid_i       (valid),
        .reqWrite_i       (write),
        .reqAddr_i        (req_addr),
        .reqMask_i        (req_mask),
        .reqData_i        (req_data),
        .reqReady_o       (reqReady_o),
        .rspValid_o       (rspValid_o),
        .rspId_o          (rspId_o),
        .rspData_o        (rspData_o),
        .memReadEnable_o  (mem_re),
        .memReadAddr_o    (mem_raddr),
        .memReadData_i    (mem_rdata),
        .memWriteEnable_o (mem_we),
        .memWriteMask_o   (mem_wmask),
        .memWriteAddr_o   (mem_waddr),
        .memWriteData_o   (mem_wdata)
    );

    // Two-port masked memory with registered read data, read-before-write.
    always @(posedge clk_i) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
        if (mem_we) begin
            for (int c = 0; c < MASK; c++)
                if (mem_wmask[c]) mem[mem_waddr][c*CW +: CW] <= mem_wdata[c*CW +: CW];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [PORTS-1:0] cand, input int ptr);
        for (int k = 0; k < PORTS; k++)
            if (cand[(ptr + k) % PORTS]) return (ptr + k) % PORTS;
        return -1;
    endfunction

    task automatic set_req(input int p, input bit v, input bit w, input int a, input int m, input int d);
        valid[p] = v;
        write[p] = w;
        addr[p]  = AW'(a);
        mask[p]  = MASK'(m);
        data[p]  = WIDTH'(d);
    endtask

    task automatic clear_all();
        for (int p = 0; p < PORTS; p++) set_req(p, 0, 0, 0, 0, 0);
    endtask

    // One cycle: check combinational grant/memory outputs mid-cycle, advance the
    // model across the edge, then check the read response just after the edge.
    task automatic step();
        int gr, gw, nid;
        bit nv;
        logic [PORTS-1:0] rd_c, wr_c, exp_rdy;
        logic [WIDTH-1:0] nd;
        @(negedge clk_i);
        rd_c = valid & ~write;
        wr_c = valid & write;
        gr = rst_n ? rr_pick(rd_c, rd_ptr) : -1;
        gw = rst_n ? rr_pick(wr_c, wr_ptr) : -1;
        exp_rdy = '0;
        if (gr >= 0) exp_rdy[gr] = 1'b1;
        if (gw >= 0) exp_rdy[gw] = 1'b1;
        obs_ready = reqReady_o;
        check_val("ready", reqReady_o, exp_rdy);
        check_val("rd_en", mem_re, gr >= 0);
        check_val("rd_addr", mem_raddr, (gr >= 0) ? addr[gr] : 0);
        check_val("wr_en", mem_we, gw >= 0);
        check_val("wr_addr", mem_waddr, (gw >= 0) ? addr[gw] : 0);
        check_val("wr_mask", mem_wmask, (gw >= 0) ? mask[gw] : 0);
        check_val("wr_data", mem_wdata, (gw >= 0) ? data[gw] : 0);
        nv  = (gr >= 0);
        nid = 0;
        nd  = '0;
        if (nv) begin
            nid    = gr;
            nd     = ref_mem[addr[gr]];
            rd_ptr = (gr + 1) % PORTS;
        end
        if (gw >= 0) begin
            for (int c = 0; c < MASK; c++)
                if (mask[gw][c]) ref_mem[addr[gw]][c*CW +: CW] = data[gw][c*CW +: CW];
            wr_ptr = (gw + 1) % PORTS;
        end
        last_gr = gr;
        last_gw = gw;
        @(posedge clk_i);
        #1;
        check_val("rsp_valid", rspValid_o, nv ? (1 << nid) : 0);
        if (nv) begin
            check_val("rsp_id", rspId_o, nid);
            check_val("rsp_data", rspData_o, nd);
        end
    endtask

    initial begin
        for (int i = 0; i < HEIGHT; i++) begin
            mem[i]     = WIDTH'($urandom);
            ref_mem[i] = mem[i];
        end
        clear_all();
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_rsp_valid", rspValid_o, 0);
        check_val("rst_rsp_id", rspId_o, 0);
        rst_n = 1'b1;

        // Idle after reset
        step();
        check_val("idle_ready", obs_ready, 0);
        check_val("idle_rd_en", mem_re, 0);
        check_val("idle_wr_en", mem_we, 0);

        // Round-robin reads from a freshly reset pointer
        for (int p = 0; p < PORTS; p++) set_req(p, 1, 0, p, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("rr_order", obs_ready, 1 << (i % PORTS));
            check_val("rr_rsp_id", rspId_o, i % PORTS);
        end

        // Write then read, single requester
        clear_all();
        set_req(2, 1, 1, 5, 4'hF, 16'hABCD);
        step();
        check_val("wr_ready", obs_ready, 4'b0100);
        set_req(2, 1, 0, 5, 0, 0);
        step();
        check_val("rd_ready", obs_ready, 4'b0100);
        check_val("wr_rd_valid", rspValid_o, 4'b0100);
        check_val("wr_rd_id", rspId_o, 2);
        check_val("wr_rd_data", rspData_o, 16'hABCD);

        // Masked write
        clear_all();
        set_req(1, 1, 1, 3, 4'hF, 16'hFFFF);
        step();
        set_req(1, 1, 1, 3, 4'b0101, 16'h1234);
        step();
        set_req(1, 1, 0, 3, 0, 0);
        step();
        check_val("mask_data", rspData_o, 16'hF2F4);

        // Same-address read and write in one cycle returns the old word
        clear_all();
        set_req(3, 1, 1, 7, 4'hF, 16'h1111);
        step();
        clear_all();
        set_req(0, 1, 0, 7, 0, 0);
        set_req(1, 1, 1, 7, 4'hF, 16'h2222);
        step();
        check_val("rbw_ready", obs_ready, 4'b0011);
        check_val("rbw_old", rspData_o, 16'h1111);
        clear_all();
        set_req(0, 1, 0, 7, 0, 0);
        step();
        check_val("rbw_new", rspData_o, 16'h2222);

        // Reset while a read response is outstanding
        clear_all();
        set_req(1, 1, 0, 3, 0, 0);
        step();
        clear_all();
        set_req(2, 1, 0, 5, 0, 0);
        step();
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_rsp_drop", rspValid_o, 0);
        check_val("rst_rsp_id_clr", rspId_o, 0);
        rd_ptr = 0;
        wr_ptr = 0;
        for (int p = 0; p < PORTS; p++) set_req(p, 1, 0, p + 8, 0, 0);
        step();
        check_val("rst_no_gnt", obs_ready, 0);
        step();
        #1 rst_n = 1'b1;
        step();
        check_val("rst_first_gnt", obs_ready, 4'b0001);

        // Randomized traffic obeying the hold-until-transfer rule
        clear_all();
        last_gr = -1;
        last_gw = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (!(valid[p] && last_gr != p && last_gw != p))
                    set_req(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                            $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 65535));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
